lsu_stall: RTL and testbench

Load-store unit between the core datapath and the data memory sized by `DATA_MEM_SIZE_BYTES`/`DATA_MEM_SIZE_WORDS` in `memory_pkg`. It converts core load/store requests (byte/half/word, signed/unsigned) into word-addressed memory transactions with byte enables. It stalls the core until memory signals ready. Addresses outside data memory are suppressed locally and never reach memory.

---
 rtl/memory_pkg.sv | 38 +++
 rtl/lsu_lane.sv | 55 +++++
 rtl/lsu_stall.sv | 140 ++++++++++++++
 tb/tb_lsu_stall.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Data-memory geometry plus load/store size encodings and LSU types.
// Shared by lsu_stall and lsu_lane.
package memory_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned DATA_MEM_SIZE_BYTES = 2048;
  localparam int unsigned DATA_MEM_SIZE_WORDS = DATA_MEM_SIZE_BYTES / 4;
  localparam logic [31:0] DATA_MEM_BASE       = 32'h0000_0000;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [2:0]      size;
    logic [XLEN-1:0] wd;
  } lsu_req_t;

  // Undefined sizes behave as words, so they need word alignment too.
  function automatic logic ldst_misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      LDST_B, LDST_BU: mis = 1'b0;
      LDST_H, LDST_HU: mis = lo[0];
      default:         mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for one direction: store replication/enables (LOAD=0)
// or load lane extraction with sign/zero extension (LOAD=1).
module lsu_lane
  import memory_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [2:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out,
  output logic [3:0]      be
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane pick for loads; address bits below the access size are ignored.
  always_comb begin
    byte_sel = data_in[7:0];
    case (addr_lo)
      2'd1:    byte_sel = data_in[15:8];
      2'd2:    byte_sel = data_in[23:16];
      2'd3:    byte_sel = data_in[31:24];
      default: byte_sel = data_in[7:0];
    endcase
    half_sel = addr_lo[1] ? data_in[31:16] : data_in[15:0];
  end

  always_comb begin
    be       = 4'b1111;
    data_out = data_in;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << addr_lo;
      LDST_H, LDST_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
    if (LOAD) begin
      case (size)
        LDST_B:  data_out = {{24{byte_sel[7]}}, byte_sel};
        LDST_BU: data_out = {24'h0, byte_sel};
        LDST_H:  data_out = {{16{half_sel[15]}}, half_sel};
        LDST_HU: data_out = {16'h0, half_sel};
        default: data_out = data_in;
      endcase
    end else begin
      case (size)
        LDST_B, LDST_BU: data_out = {4{data_in[7:0]}};
        LDST_H, LDST_HU: data_out = {2{data_in[15:0]}};
        default:         data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/lsu_stall.sv
// Load-store unit: core byte/half/word accesses to word-addressed data memory,
// stalling the core until ready. Optional macro LSU_MISALIGN_TRAP_EN suppresses
// misaligned accesses and pulses misalign_o instead of forcing alignment.
module lsu_stall
  import memory_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = ADDR_W'(DATA_MEM_BASE),
  parameter int unsigned       MEM_BYTES = DATA_MEM_SIZE_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [XLEN-1:0]   core_wd_i,
  output logic [XLEN-1:0]   core_rd_o,
  output logic              core_stall_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wd_o,
  input  logic [XLEN-1:0]   mem_rd_i,
  input  logic              mem_ready_i
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] WIN_BYTES = CMP_W'(MEM_BYTES);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, cur;
  logic [ADDR_W-1:0] req_addr_q, cur_addr;
  logic [XLEN-1:0]   rd_q;

  logic              busy, active, misal, supp, done;
  logic [CMP_W-1:0]  offset;
  logic [3:0]        fwd_be, rev_be_unused;
  logic [XLEN-1:0]   fwd_wd, rev_rd, load_res;

  // Current access: live core inputs on the request cycle, registers while busy.
  always_comb begin
    busy     = (state_q == BUSY);
    active   = busy | core_req_i;
    cur_addr = busy ? req_addr_q : core_addr_i;
    cur.we   = busy ? req_q.we   : core_we_i;
    cur.size = busy ? req_q.size : core_size_i;
    cur.wd   = busy ? req_q.wd   : core_wd_i;
  end

  // Window check via subtraction: a borrow into the top bit means below base.
  always_comb begin
    offset = {1'b0, cur_addr} - {1'b0, MEM_BASE};
`ifdef LSU_MISALIGN_TRAP_EN
    misal  = ldst_misaligned(cur.size, cur_addr[1:0]);
`else
    misal  = 1'b0;
`endif
    supp     = offset[ADDR_W] | (offset >= WIN_BYTES) | misal;
    done     = busy & (mem_ready_i | supp);
    load_res = supp ? '0 : rev_rd;
  end

  lsu_lane #(.LOAD(1'b0)) u_lane_st (
    .size     (cur.size),
    .addr_lo  (cur_addr[1:0]),
    .data_in  (cur.wd),
    .data_out (fwd_wd),
    .be       (fwd_be)
  );

  lsu_lane #(.LOAD(1'b1)) u_lane_ld (
    .size     (req_q.size),
    .addr_lo  (req_addr_q[1:0]),
    .data_in  (mem_rd_i),
    .data_out (rev_rd),
    .be       (rev_be_unused)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core_req_i) state_d = BUSY;
      BUSY:    if (done)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    core_stall_o = core_req_i & ~done;
    core_rd_o    = rd_q;
    misalign_o   = 1'b0;
    if (active && !supp) begin
      mem_req_o  = 1'b1;
      mem_we_o   = cur.we;
      mem_be_o   = fwd_be;
      mem_addr_o = {cur_addr[ADDR_W-1:2], 2'b00};
      mem_wd_o   = fwd_wd;
    end
    if (done && !req_q.we) begin
      core_rd_o = load_res;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_o = done & misal;
`endif
  end

  // Request capture on acceptance; load result held until the next load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_q <= '0;
      req_q      <= '0;
      rd_q       <= '0;
    end else begin
      if (state_q == IDLE && core_req_i) begin
        req_addr_q <= core_addr_i;
        req_q      <= cur;
      end
      if (done && !req_q.we) begin
        rd_q <= load_res;
      end
    end
  end

endmodule

// File: tb/tb_lsu_stall.sv
// Scoreboard bench for lsu_stall: expectations queued at drive time, popped on
// each completion cycle. Honours LSU_MISALIGN_TRAP_EN for misaligned cases.
module tb_lsu_stall;
  import memory_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  lsu_stall dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    int          mis;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: first-cycle snapshot, stability, stall length, result.
  int          m_cyc = 0, m_seen = 0, m_mis = 0;
  logic        m_stable;
  logic        cap_req, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wd;
  exp_t        e;

  always @(negedge clk_i) begin
    if (!rst_ni || !core_req_i) begin
      m_cyc = 0; m_seen = 0; m_mis = 0;
    end else begin
      if (m_cyc == 0) begin
        cap_req = mem_req_o; cap_we = mem_we_o; cap_be = mem_be_o;
        cap_addr = mem_addr_o; cap_wd = mem_wd_o; m_stable = 1'b1;
      end else if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !==
                   {cap_req, cap_we, cap_be, cap_addr, cap_wd}) begin
        m_stable = 1'b0;
      end
      m_cyc++;
      if (mem_req_o) m_seen++;
      if (misalign_o) m_mis++;
      if (!core_stall_o) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_req"},    32'(m_seen != 0), 32'(e.req));
          chk({e.tag, "_we"},     32'(cap_we),      32'(e.we));
          chk({e.tag, "_be"},     32'(cap_be),      32'(e.be));
          chk({e.tag, "_addr"},   cap_addr,         e.addr);
          chk({e.tag, "_wd"},     cap_wd,           e.wd);
          chk({e.tag, "_rd"},     core_rd_o,        e.rd);
          chk({e.tag, "_stall"},  32'(m_cyc - 1),   32'(e.stall));
          chk({e.tag, "_stable"}, 32'(m_stable),    32'd1);
          chk({e.tag, "_mis"},    32'(m_mis),       32'(e.mis));
        end
        m_cyc = 0; m_seen = 0; m_mis = 0;
      end
    end
  end

  // One access with a memory that raises ready after 'delay' busy cycles.
  task automatic access(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input int delay, input logic ereq, input logic [3:0] ebe,
                        input logic [31:0] eaddr, input logic [31:0] ewd,
                        input logic [31:0] erd, input int emis, input bit b2b);
    exp_t x;
    bit   fin = 1'b0;
    x.tag = tag; x.req = ereq; x.we = we & ereq; x.be = ebe; x.addr = eaddr; x.wd = ewd;
    x.rd = we ? last_rd : erd; x.stall = ereq ? delay + 1 : 1; x.mis = emis;
    if (!we) last_rd = erd;
    sb.push_back(x);
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = a; core_wd_i = wd;
    mem_rd_i = word; mem_ready_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
      mem_ready_i = (k > delay);
      @(negedge clk_i);
      if (!core_stall_o) begin fin = 1'b1; break; end
    end
    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    if (!b2b) begin
      @(posedge clk_i); #1;
      core_req_i = 1'b0; mem_ready_i = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * lo);
    case (sz)
      LDST_B:  return 32'($signed(s[7:0]));
      LDST_BU: return {24'h0, s[7:0]};
      LDST_H:  return 32'($signed(s[15:0]));
      LDST_HU: return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] lo);
    case (sz)
      LDST_B, LDST_BU: return 4'(1 << lo);
      LDST_H, LDST_HU: return lo[1] ? 4'hC : 4'h3;
      default:         return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] w);
    case (sz)
      LDST_B, LDST_BU: return {4{w[7:0]}};
      LDST_H, LDST_HU: return {2{w[15:0]}};
      default:         return w;
    endcase
  endfunction

  logic [2:0]  szs [5] = '{LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
  logic [2:0]  r_sz;
  logic [1:0]  r_lo;
  logic        r_we;
  logic [31:0] r_a, r_word, r_wd;

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mem_req",  32'(mem_req_o),    32'd0);
    chk("rst_stall",    32'(core_stall_o), 32'd0);
    chk("rst_be",       32'(mem_be_o),     32'd0);
    chk("rst_addr",     mem_addr_o,        32'h0);
    chk("rst_wd",       mem_wd_o,          32'h0);
    chk("rst_rd",       core_rd_o,         32'h0);
    chk("rst_misalign", 32'(misalign_o),   32'd0);
    rst_ni = 1'b1;

    // Reset while a store to 0x10 is pending.
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_W;
    core_addr_i = 32'h10; core_wd_i = 32'h1122_3344;
    @(posedge clk_i); #1;
    chk("midrst_busy_req",   32'(mem_req_o),    32'd1);
    chk("midrst_busy_stall", 32'(core_stall_o), 32'd1);
    rst_ni = 1'b0; core_req_i = 1'b0;
    #1;
    chk("midrst_req",  32'(mem_req_o),    32'd0);
    chk("midrst_addr", mem_addr_o,        32'h0);
    chk("midrst_stall", 32'(core_stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_stall", 32'(core_stall_o), 32'd0);
    chk("post_rst_req",   32'(mem_req_o),    32'd0);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;

    // A stale ready in IDLE must not shorten this access.
    access("lw_idle_rdy", 1'b0, LDST_W, 32'h40, 32'h0, 32'h0BAD_F00D, 2,
           1'b1, 4'hF, 32'h40, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
    access("sw", 1'b1, LDST_W, 32'h08, 32'hDEAD_BEEF, 32'h0, 0,
           1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    access("sb", 1'b1, LDST_B, 32'h0B, 32'h0000_00A5, 32'h0, 0,
           1'b1, 4'h8, 32'h08, 32'hA5A5_A5A5, 32'h0, 0, 1'b0);
    access("lb", 1'b0, LDST_B, 32'h0B, 32'h0, 32'h80FF_1234, 0,
           1'b1, 4'h8, 32'h08, 32'h0, 32'hFFFF_FF80, 0, 1'b0);
    @(negedge clk_i);
    chk("lb_hold", core_rd_o, 32'hFFFF_FF80);
    access("lbu", 1'b0, LDST_BU, 32'h0B, 32'h0, 32'h80FF_1234, 0,
           1'b1, 4'h8, 32'h08, 32'h0, 32'h0000_0080, 0, 1'b0);
    @(negedge clk_i);
    chk("lbu_hold", core_rd_o, 32'h0000_0080);
    access("sh", 1'b1, LDST_H, 32'h0E, 32'h7777_BEEF, 32'h0, 1,
           1'b1, 4'hC, 32'h0C, 32'hBEEF_BEEF, 32'h0, 0, 1'b0);
    @(negedge clk_i);
    chk("store_keeps_rd", core_rd_o, 32'h0000_0080);

    access("lh_oor", 1'b0, LDST_H, 32'h0802, 32'h0, 32'h1234_5678, 0,
           1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    access("lw_slow", 1'b0, LDST_W, 32'h100, 32'h0, 32'h1234_5678, 3,
           1'b1, 4'hF, 32'h100, 32'h0, 32'h1234_5678, 0, 1'b0);
    access("lw_top", 1'b0, LDST_W, 32'h7FC, 32'h0, 32'hCAFE_F00D, 1,
           1'b1, 4'hF, 32'h7FC, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    access("lbu_top", 1'b0, LDST_BU, 32'h7FF, 32'h0, 32'hAB00_0000, 0,
           1'b1, 4'h8, 32'h7FC, 32'h0, 32'h0000_00AB, 0, 1'b0);
    access("sw_oor", 1'b1, LDST_W, 32'h800, 32'h5555_AAAA, 32'h0, 0,
           1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    access("lw_wrap", 1'b0, LDST_W, 32'hFFFF_FFFC, 32'h0, 32'h1, 0,
           1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);

    // Back-to-back halfword loads with no idle cycle between them.
    access("lhu_b2b", 1'b0, LDST_HU, 32'h22, 32'h0, 32'h9ABC_5678, 0,
           1'b1, 4'hC, 32'h20, 32'h0, 32'h0000_9ABC, 0, 1'b1);
    access("lh_b2b_lo", 1'b0, LDST_H, 32'h20, 32'h0, 32'h9ABC_5678, 1,
           1'b1, 4'h3, 32'h20, 32'h0, 32'h0000_5678, 0, 1'b1);
    access("lh_b2b_hi", 1'b0, LDST_H, 32'h22, 32'h0, 32'h9ABC_5678, 0,
           1'b1, 4'hC, 32'h20, 32'h0, 32'hFFFF_9ABC, 0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    access("lw_mis", 1'b0, LDST_W, 32'h06, 32'h0, 32'h5566_7788, 1,
           1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0);
    access("lh_mis", 1'b0, LDST_H, 32'h03, 32'h0, 32'h8001_0000, 0,
           1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0);
`else
    access("lw_mis", 1'b0, LDST_W, 32'h06, 32'h0, 32'h5566_7788, 1,
           1'b1, 4'hF, 32'h04, 32'h0, 32'h5566_7788, 0, 1'b0);
    access("lh_mis", 1'b0, LDST_H, 32'h03, 32'h0, 32'h8001_0000, 0,
           1'b1, 4'hC, 32'h00, 32'h0, 32'hFFFF_8001, 0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      r_sz = szs[$urandom_range(0, 4)];
      r_we = 1'($urandom_range(0, 1));
      case (r_sz)
        LDST_B, LDST_BU: r_lo = 2'($urandom_range(0, 3));
        LDST_H, LDST_HU: r_lo = {1'($urandom_range(0, 1)), 1'b0};
        default:         r_lo = 2'b00;
      endcase
      r_a    = {21'h0, 9'($urandom_range(0, 511)), r_lo};
      r_word = $urandom;
      r_wd   = r_we ? 32'($urandom) : 32'h0;
      access($sformatf("rnd%0d", i), r_we, r_sz, r_a, r_wd, r_word, $urandom_range(0, 2),
             1'b1, m_be(r_sz, r_lo), {r_a[31:2], 2'b00}, m_wd(r_sz, r_wd),
             m_load(r_sz, r_lo, r_word), 0, 1'($urandom_range(0, 1)));
    end

    @(posedge clk_i); #1;
    core_req_i = 1'b0; mem_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_stall", 32'(core_stall_o), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
